// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR recovery controller and fault decoder.
package tmr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    COPY,
    PCSYNC,
    HALT
  } tmr_state_e;

  localparam logic [1:0] CORE_A = 2'd0;
  localparam logic [1:0] CORE_B = 2'd1;
  localparam logic [1:0] CORE_C = 2'd2;

  // Voter comparison vector is {A==B, B==C, A==C}
  localparam logic [2:0] CMP_OK    = 3'b111;
  localparam logic [2:0] CMP_A_BAD = 3'b010;
  localparam logic [2:0] CMP_B_BAD = 3'b001;
  localparam logic [2:0] CMP_C_BAD = 3'b100;

  localparam int unsigned NUM_CORES = 3;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned DRAIN_W   = 4;

  function automatic logic [2:0] core_onehot(input logic [1:0] id);
    core_onehot = 3'b001 << id;
  endfunction

endpackage

// File: rtl/tmr_fault_decode.sv
// Combinational decode of the voter comparison vector into a single faulty
// replica plus a healthy source, or an uncorrectable disagreement.
module tmr_fault_decode
  import tmr_pkg::*;
(
  input  logic [2:0] comp_vec,
  output logic       fault_c,
  output logic       uncorr_c,
  output logic [1:0] faulty_id_c,
  output logic [1:0] src_id_c
);

  always_comb begin
    fault_c     = 1'b0;
    uncorr_c    = 1'b0;
    faulty_id_c = CORE_A;
    src_id_c    = CORE_A;
    case (comp_vec)
      CMP_OK: ;
      CMP_A_BAD: begin
        fault_c     = 1'b1;
        faulty_id_c = CORE_A;
        src_id_c    = CORE_B;
      end
      CMP_B_BAD: begin
        fault_c     = 1'b1;
        faulty_id_c = CORE_B;
        src_id_c    = CORE_A;
      end
      CMP_C_BAD: begin
        fault_c     = 1'b1;
        faulty_id_c = CORE_C;
        src_id_c    = CORE_A;
      end
      default: uncorr_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// TMR recovery controller: stalls the cores, copies the register file and PC
// from a healthy replica into the faulty one, or halts on no majority.
// Define TMR_FAULT_CNT_EN to build the per-core saturating fault counters.
module tmr_recovery_ctrl
  import tmr_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Comp_valid,
  input  logic [2:0]           Comp_vec,
  output logic                 Stall,
  output logic                 Halt,
  output logic [RF_ADDR_W-1:0] Rf_addr,
  output logic [1:0]           Rf_src_sel,
  output logic [2:0]           Rf_we_mask,
  output logic [2:0]           Pc_load,
  output logic [CNT_W-1:0]     Fault_cnt_A,
  output logic [CNT_W-1:0]     Fault_cnt_B,
  output logic [CNT_W-1:0]     Fault_cnt_C
);

  tmr_state_e           state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [1:0]           fid_q, fid_d;
  logic [1:0]           sid_q, sid_d;
  logic                 stall_q, stall_d;
  logic                 halt_q, halt_d;
  logic [RF_ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]           src_q, src_d;
  logic [2:0]           we_q, we_d;
  logic [2:0]           pc_q, pc_d;

  logic       fault_c;
  logic       uncorr_c;
  logic [1:0] faulty_id_c;
  logic [1:0] src_id_c;

  tmr_fault_decode u_decode (
    .comp_vec    (Comp_vec),
    .fault_c     (fault_c),
    .uncorr_c    (uncorr_c),
    .faulty_id_c (faulty_id_c),
    .src_id_c    (src_id_c)
  );

  // Next state; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    fid_d   = fid_q;
    sid_d   = sid_q;
    addr_d  = '0;
    case (state_q)
      IDLE: begin
        if (Comp_valid) begin
          if (uncorr_c) begin
            state_d = HALT;
          end else if (fault_c) begin
            state_d = DRAIN;
            drain_d = '0;
            fid_d   = faulty_id_c;
            sid_d   = src_id_c;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          state_d = COPY;
          drain_d = '0;
          addr_d  = RF_ADDR_W'(1);
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      COPY: begin
        if (addr_q == RF_ADDR_W'(NUM_REGS - 1)) begin
          state_d = PCSYNC;
        end else begin
          addr_d = addr_q + RF_ADDR_W'(1);
        end
      end
      PCSYNC:  state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Stall lingers one cycle past PCSYNC so the reloaded PC settles before release
    stall_d = (state_d != IDLE) || (state_q == PCSYNC);
    halt_d  = (state_d == HALT);
    we_d    = (state_d == COPY) ? core_onehot(fid_d) : 3'b000;
    src_d   = (state_d == COPY) ? sid_d : CORE_A;
    pc_d    = (state_d == PCSYNC) ? core_onehot(fid_q) : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      fid_q   <= CORE_A;
      sid_q   <= CORE_A;
      stall_q <= 1'b0;
      halt_q  <= 1'b0;
      addr_q  <= '0;
      src_q   <= CORE_A;
      we_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      fid_q   <= fid_d;
      sid_q   <= sid_d;
      stall_q <= stall_d;
      halt_q  <= halt_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      we_q    <= we_d;
      pc_q    <= pc_d;
    end
  end

  assign Stall      = stall_q;
  assign Halt       = halt_q;
  assign Rf_addr    = addr_q;
  assign Rf_src_sel = src_q;
  assign Rf_we_mask = we_q;
  assign Pc_load    = pc_q;

`ifdef TMR_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CORES];
  logic [CNT_W-1:0] cnt_d [NUM_CORES];

  // Count completed corrections per core, saturating at all-ones
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((state_q == PCSYNC) && (fid_q == 2'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign Fault_cnt_A = cnt_q[0];
  assign Fault_cnt_B = cnt_q[1];
  assign Fault_cnt_C = cnt_q[2];
`else
  assign Fault_cnt_A = '0;
  assign Fault_cnt_B = '0;
  assign Fault_cnt_C = '0;
`endif

endmodule
